// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types, constants and helpers for the AXI-Lite RAM bridge
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Round-robin memory of which side was granted last
    localparam logic RR_READ  = 1'b0;
    localparam logic RR_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_WAIT    = 3'd1,
        ST_RD_RESP    = 3'd2,
        ST_WR_COLLECT = 3'd3,
        ST_WR_WAIT    = 3'd4,
        ST_WR_RESP    = 3'd5
    } bridge_state_t;

    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/lat_counter.sv
// rtl/lat_counter.sv - loadable down-counter with a zero flag
module lat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/axi_lite_ram_bridge.sv
// rtl/axi_lite_ram_bridge.sv - AXI4-Lite slave driving single-beat RAM requests with programmable latency
module axi_lite_ram_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic [63:0]       ram_raddr,
    input  logic [63:0]       ram_rdata,
    output logic              ram_rflag,
    output logic [63:0]       ram_waddr,
    output logic [63:0]       ram_wdata,
    output logic [63:0]       ram_wmask,
    output logic              ram_wen
);

    bridge_state_t state;
    logic          rr_last;
    logic          aw_got;
    logic          w_got;

    logic [63:0] ar_aligned;
    logic [63:0] aw_aligned;
    logic        idle;
    logic        collect;
    logic        w_side_req;
    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        wr_done;
    logic        cnt_load;
    logic [7:0]  cnt_val;
    logic        cnt_dec;
    logic        cnt_zero;

    assign ar_aligned = 64'(araddr) & ~64'h7;
    assign aw_aligned = 64'(awaddr) & ~64'h7;

    assign idle       = (state == ST_IDLE);
    assign collect    = (state == ST_WR_COLLECT);
    assign w_side_req = awvalid || wvalid;

    // On contention the side that was not granted last wins; readies are forced low during reset
    assign arready = reset && idle && !(w_side_req && (rr_last == RR_READ));
    assign awready = reset && ((idle && !(arvalid && (rr_last == RR_WRITE))) || (collect && !aw_got));
    assign wready  = reset && ((idle && !(arvalid && (rr_last == RR_WRITE))) || (collect && !w_got));

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    assign wr_done = (idle && aw_hs && w_hs) ||
                     (collect && (aw_got || aw_hs) && (w_got || w_hs));

    assign cnt_load = (idle && ar_hs) || wr_done;
    assign cnt_val  = (idle && ar_hs) ? 8'(RD_LAT - 1) : 8'(WR_LAT - 1);
    assign cnt_dec  = ((state == ST_RD_WAIT) || (state == ST_WR_WAIT)) && !cnt_zero;

    assign rresp = RESP_OKAY;
    assign bresp = RESP_OKAY;

    lat_counter #(.W(8)) u_lat (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_last   <= RR_WRITE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            bvalid    <= 1'b0;
            ram_raddr <= '0;
            ram_rflag <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_wmask <= '0;
            ram_wen   <= 1'b0;
        end else begin
            ram_rflag <= 1'b0;
            ram_wen   <= 1'b0;
            if (aw_hs) begin
                ram_waddr <= aw_aligned;
            end
            if (w_hs) begin
                ram_wdata <= wdata;
                ram_wmask <= strb_to_mask(wstrb);
            end
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        ram_raddr <= ar_aligned;
                        ram_rflag <= 1'b1;
                        rr_last   <= RR_READ;
                        state     <= ST_RD_WAIT;
                    end else if (aw_hs || w_hs) begin
                        rr_last <= RR_WRITE;
                        aw_got  <= aw_hs && !wr_done;
                        w_got   <= w_hs && !wr_done;
                        if (wr_done) begin
                            ram_wen <= 1'b1;
                            state   <= ST_WR_WAIT;
                        end else begin
                            state   <= ST_WR_COLLECT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_zero) begin
                        rdata  <= ram_rdata;
                        rvalid <= 1'b1;
                        state  <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_WR_COLLECT: begin
                    if (wr_done) begin
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        ram_wen <= 1'b1;
                        state   <= ST_WR_WAIT;
                    end else begin
                        aw_got <= aw_got || aw_hs;
                        w_got  <= w_got || w_hs;
                    end
                end
                ST_WR_WAIT: begin
                    if (cnt_zero) begin
                        bvalid <= 1'b1;
                        state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// tb/tb_axi_lite_ram_bridge.sv - scoreboard bench for the AXI-Lite RAM bridge
module tb_axi_lite_ram_bridge;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic        clock;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [63:0] ram_raddr;
    logic [63:0] ram_rdata;
    logic        ram_rflag;
    logic [63:0] ram_waddr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;
    logic        ram_wen;

    axi_lite_ram_bridge #(.ADDR_W(32), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_rflag(ram_rflag),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_wen(ram_wen)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] mask;
        int          hs;
    } exp_t;

    exp_t rq[$];
    exp_t wq[$];
    exp_t bq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_rflag = 0;
    int n_wen = 0;
    int n_rd_issued = 0;
    int n_wr_issued = 0;
    logic prev_rv = 1'b0;
    logic prev_bv = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] ram_model(input logic [63:0] a);
        case (a)
            64'h80000010: return 64'hDEADBEEF_CAFEF00D;
            64'h80000020: return 64'h01234567_89ABCDEF;
            64'h80000040: return 64'h0F0E0D0C_0B0A0908;
            default:      return 64'h55AA55AA_00000000;
        endcase
    endfunction

    assign ram_rdata = ram_model(ram_raddr);

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues
    always @(negedge clock) begin
        if (!reset) begin
            prev_rv <= 1'b0;
            prev_bv <= 1'b0;
        end else begin
            if (ram_rflag && ram_wen) fail_now("rflag_wen_overlap");
            if (ram_rflag) begin
                n_rflag++;
                if (rq.size() == 0) fail_now("rflag_unexpected");
                else begin
                    check64("rflag_timing", 64'(cyc), 64'(rq[0].hs));
                    check64("ram_raddr", ram_raddr, rq[0].addr);
                end
            end
            if (rvalid && !prev_rv) begin
                if (rq.size() == 0) fail_now("rvalid_unexpected");
                else begin
                    check64("rd_latency", 64'(cyc - rq[0].hs), 64'(RD_LAT));
                    check64("rdata", rdata, rq[0].data);
                    check64("rresp", 64'(rresp), 64'h0);
                end
            end else if (rvalid && rq.size() != 0) begin
                check64("rdata_stable", rdata, rq[0].data);
            end
            if (rvalid && rready && rq.size() != 0) void'(rq.pop_front());
            if (ram_wen) begin
                n_wen++;
                if (wq.size() == 0) fail_now("wen_unexpected");
                else begin
                    check64("wen_timing", 64'(cyc), 64'(wq[0].hs));
                    check64("ram_waddr", ram_waddr, wq[0].addr);
                    check64("ram_wdata", ram_wdata, wq[0].data);
                    check64("ram_wmask", ram_wmask, wq[0].mask);
                    bq.push_back(wq.pop_front());
                end
            end
            if (bvalid && !prev_bv) begin
                if (bq.size() == 0) fail_now("bvalid_unexpected");
                else begin
                    check64("wr_latency", 64'(cyc - bq[0].hs), 64'(WR_LAT));
                    check64("bresp", 64'(bresp), 64'h0);
                end
            end
            if (bvalid && bready && bq.size() != 0) void'(bq.pop_front());
            prev_rv <= rvalid;
            prev_bv <= bvalid;
        end
    end

    // which: 0 = arready, 1 = awready, 2 = wready; returns #1 after the handshake edge
    task automatic wait_ready(input int which);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if ((which == 0 && arready) || (which == 1 && awready) || (which == 2 && wready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("ready_timeout");
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [63:0] aligned,
                           input logic [63:0] data, output int hs);
        exp_t e;
        araddr  = addr;
        arvalid = 1'b1;
        wait_ready(0);
        arvalid = 1'b0;
        e.addr = aligned;
        e.data = data;
        e.mask = '0;
        e.hs   = cyc;
        hs     = cyc;
        rq.push_back(e);
        n_rd_issued++;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int gap, input logic [63:0] exp_addr, input logic [63:0] exp_mask,
                            output int hs);
        exp_t e;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        if (gap == 0) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            wait_ready(1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else begin
            awvalid = 1'b1;
            wait_ready(1);
            awvalid = 1'b0;
            check64("collect_arready", 64'(arready), 64'h0);
            check64("collect_awready", 64'(awready), 64'h0);
            check64("collect_wready", 64'(wready), 64'h1);
            repeat (gap) @(posedge clock);
            #1;
            wvalid = 1'b1;
            wait_ready(2);
            wvalid = 1'b0;
        end
        e.addr = exp_addr;
        e.data = data;
        e.mask = exp_mask;
        e.hs   = cyc;
        hs     = cyc;
        wq.push_back(e);
        n_wr_issued++;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rq.size() == 0 && wq.size() == 0 && bq.size() == 0 && !rvalid && !bvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check64({tag, "_arready"}, 64'(arready), 64'h0);
        check64({tag, "_awready"}, 64'(awready), 64'h0);
        check64({tag, "_wready"}, 64'(wready), 64'h0);
        check64({tag, "_rvalid"}, 64'(rvalid), 64'h0);
        check64({tag, "_bvalid"}, 64'(bvalid), 64'h0);
        check64({tag, "_rflag"}, 64'(ram_rflag), 64'h0);
        check64({tag, "_wen"}, 64'(ram_wen), 64'h0);
        check64({tag, "_rdata"}, rdata, 64'h0);
        check64({tag, "_raddr"}, ram_raddr, 64'h0);
        check64({tag, "_waddr"}, ram_waddr, 64'h0);
        check64({tag, "_wdata"}, ram_wdata, 64'h0);
        check64({tag, "_wmask"}, ram_wmask, 64'h0);
        check64({tag, "_resp"}, {60'h0, rresp, bresp}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_hs;
        int wr_hs;
        int dummy;
        bit seen;

        reset   = 1'b0;
        araddr  = '0;
        awaddr  = '0;
        wdata   = '0;
        wstrb   = '0;
        rready  = 1'b1;
        bready  = 1'b1;
        // Valids high during reset: readies must still read 0
        arvalid = 1'b1;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Simultaneous read and write from reset: read wins first
        fork
            do_read(32'h80000020, 64'h80000020, 64'h01234567_89ABCDEF, rd_hs);
            do_write(32'h80000030, 64'hAABBCCDD_EEFF0011, 8'hF0, 0,
                     64'h80000030, 64'hFFFFFFFF_00000000, wr_hs);
        join
        check64("read_granted_first", 64'(rd_hs < wr_hs), 64'h1);
        drain();

        do_read(32'h80000010, 64'h80000010, 64'hDEADBEEF_CAFEF00D, dummy);
        drain();

        do_write(32'h80000008, 64'h11223344_55667788, 8'h0F, 2,
                 64'h80000008, 64'h00000000_FFFFFFFF, dummy);
        drain();

        do_write(32'h80000005, 64'hCAFEBABE_12345678, 8'hFF, 0,
                 64'h80000000, 64'hFFFFFFFF_FFFFFFFF, dummy);
        drain();

        do_write(32'h80000018, 64'h99999999_99999999, 8'h00, 1,
                 64'h80000018, 64'h00000000_00000000, dummy);
        drain();

        // Back-pressure: rvalid held, no new AR accepted
        rready = 1'b0;
        do_read(32'h80000044, 64'h80000040, 64'h0F0E0D0C_0B0A0908, dummy);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("bp_rvalid_timeout");
        araddr  = 32'h80000010;
        arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check64("bp_rvalid_held", 64'(rvalid), 64'h1);
            check64("bp_no_arready", 64'(arready), 64'h0);
        end
        @(posedge clock);
        #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        drain();

        // Reset in RD_WAIT drops the read
        do_read(32'h80000010, 64'h80000010, 64'hDEADBEEF_CAFEF00D, dummy);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        rq.delete();
        check_idle_outputs("midreset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check64("post_reset_no_rvalid", 64'(rvalid), 64'h0);
        end
        @(posedge clock);
        #1;
        do_read(32'h80000020, 64'h80000020, 64'h01234567_89ABCDEF, dummy);
        drain();

        check64("rflag_count", 64'(n_rflag), 64'(n_rd_issued));
        check64("wen_count", 64'(n_wen), 64'(n_wr_issued));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram_bridge.md
Name: axi_lite_ram_bridge

Overview:
AXI4-Lite slave that turns core/LSU memory transactions into the single-beat request signals used by the simulation RAM controller (raddr/rdata/rflag/waddr/wdata/wmask/wen).
Sits directly upstream of the RAM controller.
Adds a programmable access latency so pipeline stall paths are exercised in simulation.
Serialises reads and writes; at most one transaction is in flight.

Parameters:
ADDR_W, 32, AXI address width; zero-extended to 64 bits on the RAM side.
RD_LAT, 1, cycles from AR acceptance to RVALID (>=1).
WR_LAT, 1, cycles from AW+W capture to BVALID (>=1).

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-low (0 = reset)
araddr  in  ADDR_W  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  64  read data
rresp  out  2  read response, always 2'b00
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  ADDR_W  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  64  write data
wstrb  in  8  write byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response, always 2'b00
bvalid  out  1  write response valid
bready  in  1  write response ready
ram_raddr  out  64  RAM read address
ram_rdata  in  64  RAM read data, combinational from ram_raddr
ram_rflag  out  1  one-cycle pulse marking the start of a read
ram_waddr  out  64  RAM write address
ram_wdata  out  64  RAM write data
ram_wmask  out  64  byte-expanded write mask
ram_wen  out  1  RAM write enable, one-cycle pulse

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all valid/ready/pulse outputs 0; all address/data/mask outputs 0; rresp/bresp 0; FSM in IDLE; rr_last = WRITE.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP.
- IDLE:
  - arready = awready = wready = 1 only in IDLE and WR_COLLECT; arready is 0 in WR_COLLECT.
  - AR handshake: latch address with low 3 bits cleared; ram_raddr = latched address; ram_rflag = 1 for the next cycle only; load latency counter with RD_LAT-1; go to RD_WAIT.
  - AW and/or W handshake: latch whichever arrived; if both arrived go to WR_WAIT, else go to WR_COLLECT.
- Simultaneous arvalid and (awvalid or wvalid) in IDLE: round-robin. Grant the side not in rr_last; update rr_last on each grant. The losing side's ready is 0 that cycle.
- RD_WAIT:
  - ram_raddr held stable.
  - Counter decrements; at 0, capture ram_rdata into the rdata register, assert rvalid, go to RD_RESP.
  - RD_LAT = 1 means rvalid in the cycle after the AR handshake.
- RD_RESP: hold rvalid and rdata until rready; on handshake, rvalid = 0 and go to IDLE.
- WR_COLLECT: wait for the missing AW or W; the already-captured channel's ready is 0. When complete, go to WR_WAIT.
- WR_WAIT:
  - On entry, ram_wen = 1 for exactly one cycle.
  - ram_waddr = aligned address.
  - ram_wdata = wdata.
  - ram_wmask byte i = {8{wstrb[i]}}.
  - Counter starts at WR_LAT-1; at 0, assert bvalid and go to WR_RESP.
- WR_RESP: hold bvalid until bready, then go to IDLE.
- wstrb = 0: ram_wen still pulses with an all-zero mask; response is OKAY.
- rready/bready already high when valid rises: handshake completes in that cycle; the next request can be accepted the cycle after.
- Reset asserted mid-transaction: asynchronous return to IDLE with all outputs at reset values; the transaction is dropped with no response.
- ram_rflag and ram_wen never assert in the same cycle.

Decomposition:
- Shared package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00
  - the bridge state enum
  - a function strb_to_mask (8 -> 64 bits)
- Sub-module lat_counter: loadable down-counter with a zero flag, one instance per direction or one shared instance (reads and writes are exclusive).

Test Plan:
- Read, RD_LAT=3: araddr=0x80000010, RAM returns 0xDEADBEEF_CAFEF00D -> rflag pulses the cycle after AR; rvalid rises 3 cycles after the AR handshake; rdata = 0xDEADBEEF_CAFEF00D.
- Write, AW then W two cycles later: awaddr=0x80000008, wdata=0x1122334455667788, wstrb=0x0F -> one ram_wen pulse; ram_wmask = 0x00000000FFFFFFFF; BVALID after WR_LAT; bresp = 0.
- Simultaneous AR and AW+W from reset -> read granted first (rr_last reset = WRITE); write granted next; exactly one rflag and one wen.
- Back-pressure: rready held low 5 cycles -> rvalid and rdata stable throughout; no new arready until the handshake.
- Unaligned awaddr=0x80000005, wstrb=0xFF -> ram_waddr = 0x80000000; mask all ones.
- Reset pulled low during RD_WAIT -> all outputs 0 immediately; no rvalid after release; a subsequent read completes normally.
